// File: rtl/dmem_if.sv
// Request/response bus between a data-memory requester (master) and the
// dmem_responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_w;
    logic [3:0]  mem_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] mem_r;
    logic        resp_err;

    modport master (
        output req_valid, mem_r_en, mem_w_en, mem_addr, mem_w, mem_wmask, resp_ready,
        input  req_ready, resp_valid, mem_r, resp_err
    );

    modport slave (
        input  req_valid, mem_r_en, mem_w_en, mem_addr, mem_w, mem_wmask, resp_ready,
        output req_ready, resp_valid, mem_r, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed (or, with DMEM_RESP_RAND_DELAY_EN,
// LFSR-jittered) response latency and access-fault reporting.
//
// state | meaning
// IDLE  | req_ready high, waiting for req_valid
// WAIT  | request captured, counting down the response delay
// RESP  | response registered, resp_valid held until resp_ready
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE       = 32'h8000_0000
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    localparam int          CNT_W = 5;
    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd4 << DEPTH_LOG2);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        load_val;
    logic                    r_en_q;
    logic                    w_en_q;
    logic [31:0]             addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              mask_q;
    logic [31:0]             mem [WORDS];

    logic                    accept;
    logic                    do_op;
    logic                    op_r;
    logic                    op_w;
    logic [31:0]             op_addr;
    logic [31:0]             op_wdata;
    logic [3:0]              op_mask;
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    fault;

`ifdef DMEM_RESP_RAND_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr <= 8'hA5;
        else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign load_val = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
    assign load_val = CNT_W'(LATENCY);
`endif

    assign accept = (state == IDLE) && bus.req_ready && bus.req_valid;

    // A zero delay executes on the accept edge itself, before the capture
    // registers hold the request, so the live inputs are used in IDLE.
    always_comb begin
        op_r     = r_en_q;
        op_w     = w_en_q;
        op_addr  = addr_q;
        op_wdata = wdata_q;
        op_mask  = mask_q;
        if (state == IDLE) begin
            op_r     = bus.mem_r_en;
            op_w     = bus.mem_w_en;
            op_addr  = bus.mem_addr;
            op_wdata = bus.mem_w;
            op_mask  = bus.mem_wmask;
        end
    end

    assign idx   = DEPTH_LOG2'((op_addr - BASE) >> 2);
    assign fault = ({1'b0, op_addr} < {1'b0, BASE}) || ({1'b0, op_addr} >= LIMIT) ||
                   (op_addr[1:0] != 2'b00) || (op_r && op_w);
    assign do_op = (accept && (load_val == '0)) || ((state == WAIT) && (cnt == '0));

    // Array contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (do_op && op_w && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (op_mask[b]) mem[idx][8*b +: 8] <= op_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.mem_r      <= '0;
            bus.resp_err   <= 1'b0;
            r_en_q         <= 1'b0;
            w_en_q         <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            mask_q         <= '0;
        end else begin
            if (do_op) begin
                bus.mem_r    <= (op_r && !fault) ? mem[idx] : '0;
                bus.resp_err <= fault;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_en_q        <= bus.mem_r_en;
                        w_en_q        <= bus.mem_w_en;
                        addr_q        <= bus.mem_addr;
                        wdata_q       <= bus.mem_w;
                        mask_q        <= bus.mem_wmask;
                        cnt           <= load_val;
                        bus.req_ready <= 1'b0;
                        if (load_val == '0) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    // req_ready rises only with the return to IDLE, so no
                    // request is accepted on the handshake cycle.
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, giving log2 of the number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, giving wait cycles between request accept and response (0..15).
REQ-003 SHALL have parameter BASE, default 32'h8000_0000, giving the byte address of word 0.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port mem_r_en  input  1  read request.
REQ-009 SHALL have port mem_w_en  input  1  write request.
REQ-010 SHALL have port mem_addr  input  32  byte address.
REQ-011 SHALL have port mem_w  input  32  write data.
REQ-012 SHALL have port mem_wmask  input  4  byte-lane write enables; bit i writes mem_w[8i+7:8i].
REQ-013 SHALL have port resp_valid  output  1  response present.
REQ-014 SHALL have port resp_ready  input  1  requester consumes response.
REQ-015 SHALL have port mem_r  output  32  read data.
REQ-016 SHALL have port resp_err  output  1  access fault.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE; accept occurs on a cycle with req_valid && req_ready.
REQ-019 SHALL capture addr, data, mask and enables on accept, then ignore input changes until the next accept.
REQ-020 SHALL go IDLE->WAIT on accept with a wait counter loaded to LATENCY; if the loaded value is 0, SHALL go IDLE->RESP directly.
REQ-021 SHALL decrement the counter each WAIT cycle and go WAIT->RESP when it reaches 0, so resp_valid first rises LATENCY+1 cycles after the accept edge.
REQ-022 SHALL perform the array read/write on the transition into RESP; mem_r and resp_err SHALL be registered and stable while resp_valid=1.
REQ-023 SHALL hold resp_valid=1 in RESP until resp_valid && resp_ready, then return to IDLE; it SHALL not accept a new request in that same cycle.
REQ-024 SHALL form word index = (addr-BASE)[DEPTH_LOG2+1:2].
REQ-025 SHALL set resp_err=1 on fault: addr<BASE, addr>=BASE+4*2^DEPTH_LOG2, addr[1:0]!=0, or mem_r_en&&mem_w_en; on a fault it SHALL not write and SHALL return mem_r=0.
REQ-026 SHALL return mem_r=stored word on a read, and mem_r=0 on a write.
REQ-027 SHALL complete a request with mem_r_en=mem_w_en=0 as a no-op with resp_err=0 and mem_r=0.
REQ-028 SHALL apply mem_wmask=4'b0000 as a write of no bytes, with no error.

Reset
REQ-029 SHALL, while rst=0, force state IDLE, req_ready=0, resp_valid=0, mem_r=0, resp_err=0 and counter=0.
REQ-030 SHALL drop any in-flight request on reset mid-operation, leaving the array unmodified by it; array contents are not reset.
REQ-031 SHALL assert req_ready=1 from the first clock edge after rst deasserts.

Configuration
REQ-032 SHALL, with macro DMEM_RESP_RAND_DELAY_EN defined, load the wait counter with LATENCY+lfsr[1:0], where lfsr is an 8-bit Fibonacci LFSR (taps 8,6,5,4), reset to 8'hA5, advancing every cycle.
REQ-033 SHALL, without DMEM_RESP_RAND_DELAY_EN, use a fixed LATENCY and contain no LFSR logic.

Verification (LATENCY=2, macro undefined, resp_ready=1 unless stated)
REQ-034 SHALL cover: write 0x8000_0010 data 0xDEADBEEF mask 4'hF, then read 0x8000_0010 -> read mem_r=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after each accept.
REQ-035 SHALL cover: write 0x1122_3344 mask 4'hF, then write 0xAABB_CCDD mask 4'b0101 to the same word, then read -> mem_r=0x11BB_33DD.
REQ-036 SHALL cover: read 0x8000_0012, read 0x7FFF_FFFC, read 0x8000_1000 (DEPTH_LOG2=10), and r_en=w_en=1 -> resp_err=1 and mem_r=0 for each, array unchanged.
REQ-037 SHALL cover: resp_ready held 0 for 5 cycles during RESP -> resp_valid, mem_r and resp_err stable, req_ready=0; one accept only after the handshake.
REQ-038 SHALL cover: rst pulled low in WAIT of a write of 0x5555_5555 -> outputs at reset values immediately, a later read of that word returns its prior value.
REQ-039 SHALL cover: with DMEM_RESP_RAND_DELAY_EN, 20 back-to-back reads -> every latency is in 3..6 cycles, and the data is correct.
